// File: rtl/truth_table_sweeper.sv
// Drives all 16 input vectors of a 4-input function, samples its output after a settle
// interval, and checks the captured truth table against a golden word.
module truth_table_sweeper #(
    parameter int          SETTLE   = 2,
    parameter logic [15:0] EXPECTED = 16'hAC3C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        s_in,
    output logic [3:0]  vec,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err
);
    localparam int             CW       = $clog2(SETTLE + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, FIN} state_t;

    // start/stop handshake: start is a level sampled at each edge while IDLE or on the
    // edge that leaves FIN; busy is high while vectors are being driven; done pulses
    // for one cycle after the last sample.
    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [3:0]     vec_nxt, first_err_nxt;
    logic           busy_nxt, done_nxt, pass_nxt;
    logic [15:0]    result_nxt;
    logic [4:0]     err_count_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            first_err <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            vec       <= vec_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            result    <= result_nxt;
            pass      <= pass_nxt;
            err_count <= err_count_nxt;
            first_err <= first_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        vec_nxt       = vec;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        result_nxt    = result;
        pass_nxt      = pass;
        err_count_nxt = err_count;
        first_err_nxt = first_err;

        case (state)
            IDLE, FIN: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
                // The edge closing FIN also samples start, so a held start
                // restarts immediately after done.
                if (start) begin
                    state_nxt     = SWEEP;
                    cnt_nxt       = '0;
                    vec_nxt       = '0;
                    busy_nxt      = 1'b1;
                    result_nxt    = '0;
                    pass_nxt      = 1'b0;
                    err_count_nxt = '0;
                    first_err_nxt = '0;
                end
            end
            SWEEP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt         = '0;
                    result_nxt[vec] = s_in;
                    if (s_in != EXPECTED[vec]) begin
                        err_count_nxt = err_count + 5'd1;
                        if (err_count == 5'd0) first_err_nxt = vec;
                    end
                    if (vec == 4'd15) begin
                        state_nxt = FIN;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_count_nxt == 5'd0);
                    end else begin
                        vec_nxt = vec + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
